// File: rtl/bus_arbiter2.sv
// Two-master, one-slave round-robin bus arbiter with a per-transaction watchdog.
// Completion (ack/err/rdata) is combinational from the slave ack in the grant cycle.
module bus_arbiter2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_req0,
    input  logic [ADDR_WIDTH-1:0] I_addr0,
    input  logic [DATA_WIDTH-1:0] I_wdata0,
    input  logic                  I_we0,
    output logic                  O_ack0,
    output logic                  O_err0,
    output logic [DATA_WIDTH-1:0] O_rdata0,
    input  logic                  I_req1,
    input  logic [ADDR_WIDTH-1:0] I_addr1,
    input  logic [DATA_WIDTH-1:0] I_wdata1,
    input  logic                  I_we1,
    output logic                  O_ack1,
    output logic                  O_err1,
    output logic [DATA_WIDTH-1:0] O_rdata1,
    output logic                  O_s_req,
    output logic [ADDR_WIDTH-1:0] O_s_addr,
    output logic [DATA_WIDTH-1:0] O_s_wdata,
    output logic                  O_s_we,
    input  logic                  I_s_ack,
    input  logic [DATA_WIDTH-1:0] I_s_rdata,
    output logic                  O_sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state_r, state_s;
    logic       last_r, last_s;
    logic       sel_r, sel_s;
    logic [7:0] wd_r, wd_s;
    logic       granted_s;
    logic       expire_s;
    logic       done_s;

    // State, arbitration history, mux select and watchdog registers
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            sel_r   <= 1'b0;
            wd_r    <= 8'd0;
        end else begin
            state_r <= state_s;
            last_r  <= last_s;
            sel_r   <= sel_s;
            wd_r    <= wd_s;
        end
    end

    // Next-state: round-robin arbitration in IDLE, completion or timeout in GRANTn
    always_comb begin
        state_s = state_r;
        last_s  = last_r;
        sel_s   = sel_r;
        wd_s    = wd_r;
        case (state_r)
            IDLE: begin
                wd_s = 8'd0;
                if (I_req0 && I_req1) begin
                    if (last_r) begin
                        state_s = GRANT0;
                        sel_s   = 1'b0;
                        last_s  = 1'b0;
                    end else begin
                        state_s = GRANT1;
                        sel_s   = 1'b1;
                        last_s  = 1'b1;
                    end
                end else if (I_req0) begin
                    state_s = GRANT0;
                    sel_s   = 1'b0;
                    last_s  = 1'b0;
                end else if (I_req1) begin
                    state_s = GRANT1;
                    sel_s   = 1'b1;
                    last_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT0, GRANT1: begin
                if (I_s_ack || (wd_r == WD_LAST)) begin
                    state_s = IDLE;
                    wd_s    = 8'd0;
                end else begin
                    wd_s = wd_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                wd_s    = 8'd0;
            end
        endcase
    end

    // Slave-side mux and master completion signalling; a reset cycle suppresses any ack
    always_comb begin
        granted_s = (state_r != IDLE);
        expire_s  = granted_s && !I_s_ack && (wd_r == WD_LAST);
        done_s    = granted_s && !I_rst && (I_s_ack || (wd_r == WD_LAST));
        O_s_req   = granted_s;
        O_sel     = sel_r;
        O_s_addr  = {ADDR_WIDTH{1'b0}};
        O_s_wdata = {DATA_WIDTH{1'b0}};
        O_s_we    = 1'b0;
        O_ack0    = 1'b0;
        O_err0    = 1'b0;
        O_rdata0  = {DATA_WIDTH{1'b0}};
        O_ack1    = 1'b0;
        O_err1    = 1'b0;
        O_rdata1  = {DATA_WIDTH{1'b0}};
        if (granted_s) begin
            if (sel_r) begin
                O_s_addr  = I_addr1;
                O_s_wdata = I_wdata1;
                O_s_we    = I_we1;
            end else begin
                O_s_addr  = I_addr0;
                O_s_wdata = I_wdata0;
                O_s_we    = I_we0;
            end
        end else begin
            O_s_we = 1'b0;
        end
        if (done_s && (state_r == GRANT0)) begin
            O_ack0   = 1'b1;
            O_err0   = expire_s;
            O_rdata0 = I_s_ack ? I_s_rdata : {DATA_WIDTH{1'b0}};
        end else if (done_s && (state_r == GRANT1)) begin
            O_ack1   = 1'b1;
            O_err1   = expire_s;
            O_rdata1 = I_s_ack ? I_s_rdata : {DATA_WIDTH{1'b0}};
        end else begin
            O_ack0 = 1'b0;
            O_ack1 = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Scoreboard bench for bus_arbiter2: directed stimulus pushes expected completions,
// a negedge monitor pops and compares on every master ack.
module tb_bus_arbiter2;

    logic        clk = 1'b0;
    logic        I_rst, I_req0, I_req1, I_we0, I_we1, I_s_ack;
    logic [31:0] I_addr0, I_addr1, I_wdata0, I_wdata1, I_s_rdata;
    logic        O_ack0, O_err0, O_ack1, O_err1, O_s_req, O_s_we, O_sel;
    logic [31:0] O_rdata0, O_rdata1, O_s_addr, O_s_wdata;

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          pend[2];
    int          slave_lat;
    logic [31:0] slave_data;
    int          n_checks = 0;
    int          n_fail   = 0;

    bus_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .I_clk(clk), .I_rst(I_rst),
        .I_req0(I_req0), .I_addr0(I_addr0), .I_wdata0(I_wdata0), .I_we0(I_we0),
        .O_ack0(O_ack0), .O_err0(O_err0), .O_rdata0(O_rdata0),
        .I_req1(I_req1), .I_addr1(I_addr1), .I_wdata1(I_wdata1), .I_we1(I_we1),
        .O_ack1(O_ack1), .O_err1(O_err1), .O_rdata1(O_rdata1),
        .O_s_req(O_s_req), .O_s_addr(O_s_addr), .O_s_wdata(O_s_wdata), .O_s_we(O_s_we),
        .I_s_ack(I_s_ack), .I_s_rdata(I_s_rdata), .O_sel(O_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic err, input logic [31:0] rdata,
                            input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        exp_t e;
        e.id = id; e.err = err; e.rdata = rdata; e.addr = addr; e.we = we; e.wdata = wdata;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int id, input int max, output int n);
        int t;
        n = 0;
        t = 0;
        forever begin
            @(negedge clk);
            t++;
            if (O_s_req) n++;
            if ((id == 0 && O_ack0) || (id == 1 && O_ack1)) break;
            if (t >= max) begin
                check("wait_ack_timeout", 32'(t), 32'(max + 1));
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((pend[0] > 0 || pend[1] > 0 || O_s_req) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("wait_idle_timeout", 32'(t), 32'd0);
        cyc();
        cyc();
    endtask

    // Requesters: hold request while transactions remain outstanding
    initial begin
        I_req0 = 1'b0;
        I_req1 = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            I_req0 = (pend[0] > 0);
            I_req1 = (pend[1] > 0);
        end
    end

    // Slave: acks on the slave_lat-th grant cycle (0 = never), junk data otherwise
    initial begin
        int cnt;
        cnt       = 0;
        I_s_ack   = 1'b0;
        I_s_rdata = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            #2;
            if (O_s_req) begin
                cnt++;
                if (slave_lat != 0 && cnt == slave_lat) begin
                    I_s_ack   = 1'b1;
                    I_s_rdata = slave_data;
                end else begin
                    I_s_ack   = 1'b0;
                    I_s_rdata = 32'hBAD0_BAD0;
                end
            end else begin
                cnt       = 0;
                I_s_ack   = 1'b0;
                I_s_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Monitor: every ack pops one expected completion
    initial begin
        exp_t e;
        int   id;
        forever begin
            @(negedge clk);
            if (O_ack0 || O_ack1) begin
                check("ack_exclusive", 32'(O_ack0 & O_ack1), 32'd0);
                id = O_ack1 ? 1 : 0;
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("mon_id", 32'(id), 32'(e.id));
                    check("mon_err", 32'(id == 1 ? O_err1 : O_err0), 32'(e.err));
                    check("mon_rdata", id == 1 ? O_rdata1 : O_rdata0, e.rdata);
                    check("mon_other_rdata", id == 1 ? O_rdata0 : O_rdata1, 32'd0);
                    check("mon_sel", 32'(O_sel), 32'(e.id));
                    check("mon_addr", O_s_addr, e.addr);
                    check("mon_we", 32'(O_s_we), 32'(e.we));
                    if (e.we) check("mon_wdata", O_s_wdata, e.wdata);
                end
                pend[id] = pend[id] - 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        pend[0] = 0; pend[1] = 0;
        slave_lat = 0; slave_data = 32'd0;
        I_rst = 1'b1;
        I_addr0 = 32'h1111_1111; I_wdata0 = 32'h2222_2222; I_we0 = 1'b1;
        I_addr1 = 32'h3333_3333; I_wdata1 = 32'h4444_4444; I_we1 = 1'b1;
        repeat (2) cyc();
        I_rst = 1'b0;
        I_we0 = 1'b0; I_we1 = 1'b0;
        @(negedge clk);
        check("rst_s_req", 32'(O_s_req), 32'd0);
        check("rst_sel", 32'(O_sel), 32'd0);
        check("rst_acks", 32'({O_ack0, O_ack1, O_err0, O_err1}), 32'd0);
        check("rst_s_addr", O_s_addr, 32'd0);
        check("rst_s_wdata", O_s_wdata, 32'd0);
        check("rst_rdata", O_rdata0 | O_rdata1, 32'd0);

        // Single master 0 read, slave acks in the first grant cycle
        cyc();
        I_addr0 = 32'h0000_FFFF; I_wdata0 = 32'h7777_7777;
        slave_lat = 1; slave_data = 32'hDEAD_BEEF;
        push_exp(0, 1'b0, 32'hDEAD_BEEF, 32'h0000_FFFF, 1'b0, 32'd0);
        pend[0] = 1;
        @(negedge clk);
        check("t1_c0_idle", 32'(O_s_req), 32'd0);
        @(negedge clk);
        check("t1_c1_s_req", 32'(O_s_req), 32'd1);
        check("t1_c1_sel", 32'(O_sel), 32'd0);
        check("t1_c1_addr", O_s_addr, 32'h0000_FFFF);
        check("t1_c1_ack0", 32'(O_ack0), 32'd1);
        @(negedge clk);
        check("t1_c2_idle", 32'(O_s_req), 32'd0);
        wait_idle();

        // Tie after reset: expect 0,1,0,1
        I_rst = 1'b1;
        cyc();
        I_rst = 1'b0;
        I_addr0 = 32'h1000_0000; I_addr1 = 32'h2000_0000;
        slave_lat = 2; slave_data = 32'h1234_5678;
        push_exp(0, 1'b0, 32'h1234_5678, 32'h1000_0000, 1'b0, 32'd0);
        push_exp(1, 1'b0, 32'h1234_5678, 32'h2000_0000, 1'b0, 32'd0);
        push_exp(0, 1'b0, 32'h1234_5678, 32'h1000_0000, 1'b0, 32'd0);
        push_exp(1, 1'b0, 32'h1234_5678, 32'h2000_0000, 1'b0, 32'd0);
        pend[0] = 2; pend[1] = 2;
        wait_idle();

        // Master 1 write muxing
        slave_lat = 1; slave_data = 32'h5A5A_0001;
        I_addr1 = 32'h0000_0040; I_wdata1 = 32'hFFFF_0000; I_we1 = 1'b1;
        push_exp(1, 1'b0, 32'h5A5A_0001, 32'h0000_0040, 1'b1, 32'hFFFF_0000);
        pend[1] = 1;
        wait_ack(1, 20, n);
        check("t3_grant_cycles", 32'(n), 32'd1);
        wait_idle();
        I_we1 = 1'b0;

        // Timeout: slave never acks -> error on the 16th grant cycle
        slave_lat = 0;
        I_addr0 = 32'h0000_0100;
        push_exp(0, 1'b1, 32'd0, 32'h0000_0100, 1'b0, 32'd0);
        pend[0] = 1;
        wait_ack(0, 40, n);
        check("t4_timeout_cycles", 32'(n), 32'd16);
        @(negedge clk);
        check("t4_release", 32'(O_s_req), 32'd0);
        wait_idle();

        // Ack on exactly the 16th grant cycle wins over the timeout
        slave_lat = 16; slave_data = 32'h0F0F_1616;
        push_exp(0, 1'b0, 32'h0F0F_1616, 32'h0000_0100, 1'b0, 32'd0);
        pend[0] = 1;
        wait_ack(0, 40, n);
        check("t4b_ack_cycles", 32'(n), 32'd16);
        @(negedge clk);
        check("t4b_release", 32'(O_s_req), 32'd0);
        wait_idle();

        // Contention: master 1 requests mid-grant of master 0
        slave_lat = 4; slave_data = 32'hC0DE_0005;
        I_addr0 = 32'h0000_0200; I_addr1 = 32'h0000_0300;
        push_exp(0, 1'b0, 32'hC0DE_0005, 32'h0000_0200, 1'b0, 32'd0);
        push_exp(1, 1'b0, 32'hC0DE_0005, 32'h0000_0300, 1'b0, 32'd0);
        pend[0] = 1;
        cyc();
        cyc();
        pend[1] = 1;
        @(negedge clk);
        check("t5_req1_ignored_sel", 32'(O_sel), 32'd0);
        check("t5_req1_ignored_addr", O_s_addr, 32'h0000_0200);
        wait_ack(0, 20, n);
        @(negedge clk);
        check("t5_idle_gap", 32'(O_s_req), 32'd0);
        @(negedge clk);
        check("t5_grant1_req", 32'(O_s_req), 32'd1);
        check("t5_grant1_sel", 32'(O_sel), 32'd1);
        wait_idle();

        // Reset in the 3rd grant cycle abandons the transaction
        slave_lat = 0;
        I_addr0 = 32'h0000_0400; I_addr1 = 32'h0000_0500;
        pend[0] = 1;
        cyc();
        cyc();
        cyc();
        check("t6_in_grant", 32'(O_s_req), 32'd1);
        I_rst = 1'b1;
        slave_lat = 1; slave_data = 32'hCAFE_F00D;
        push_exp(0, 1'b0, 32'hCAFE_F00D, 32'h0000_0400, 1'b0, 32'd0);
        push_exp(1, 1'b0, 32'hCAFE_F00D, 32'h0000_0500, 1'b0, 32'd0);
        pend[1] = 1;
        cyc();
        I_rst = 1'b0;
        @(negedge clk);
        check("t6_s_req", 32'(O_s_req), 32'd0);
        check("t6_acks", 32'({O_ack0, O_ack1, O_err0, O_err1}), 32'd0);
        check("t6_sel", 32'(O_sel), 32'd0);
        check("t6_s_addr", O_s_addr, 32'd0);
        check("t6_s_we", 32'(O_s_we), 32'd0);
        check("t6_rdata", O_rdata0 | O_rdata1, 32'd0);
        wait_idle();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
